// File: rtl/decode_stage.sv
// Registered RV32I decode stage: one instruction in per valid/ready transfer,
// full control bundle out one cycle later, plus saturating debug counters.
module decode_stage #(
    parameter int XLEN          = 32,
    parameter int CNT_WIDTH     = 16,
    parameter bit STRICT_DECODE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [XLEN-1:0]      in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [31:0]          out_instr,
    output logic [3:0]           alu_control,
    output logic [2:0]           imm_source,
    output logic                 alu_source,
    output logic [1:0]           write_back_source,
    output logic                 second_add_source,
    output logic                 reg_write,
    output logic                 mem_write,
    output logic [2:0]           mem_func3,
    output logic                 branch,
    output logic [2:0]           branch_cond,
    output logic                 jump,
    output logic                 jalr,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic [CNT_WIDTH-1:0] illegal_count
);
    // Handshake: a transfer happens on an edge where valid and ready are both 1.
    // out_valid/bundle hold while out_ready is 0; flush kills both the held and
    // the offered instruction.
    typedef struct packed {
        logic [3:0] alu_control;
        logic [2:0] imm_source;
        logic       alu_source;
        logic [1:0] write_back_source;
        logic       second_add_source;
        logic       reg_write;
        logic       mem_write;
        logic [2:0] mem_func3;
        logic       branch;
        logic [2:0] branch_cond;
        logic       jump;
        logic       jalr;
        logic       illegal;
    } ctrl_t;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                           ALU_SLL = 4'd4, ALU_SLT = 4'd5, ALU_SRL = 4'd6, ALU_SLTU = 4'd7,
                           ALU_XOR = 4'd8, ALU_SRA = 4'd9;

    ctrl_t       dec, ctrl_q;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic        bad, alt;
    logic        load;

    assign op  = in_instr[6:0];
    assign f3  = in_instr[14:12];
    assign f7  = in_instr[31:25];
    assign alt = in_instr[30];

    function automatic logic [3:0] alu_of(input logic [2:0] fn3, input logic sub_sra);
        case (fn3)
            3'b000:  alu_of = sub_sra ? ALU_SUB : ALU_ADD;
            3'b001:  alu_of = ALU_SLL;
            3'b010:  alu_of = ALU_SLT;
            3'b011:  alu_of = ALU_SLTU;
            3'b100:  alu_of = ALU_XOR;
            3'b101:  alu_of = sub_sra ? ALU_SRA : ALU_SRL;
            3'b110:  alu_of = ALU_OR;
            default: alu_of = ALU_AND;
        endcase
    endfunction

    always_comb begin
        dec = '0;
        bad = 1'b0;
        case (op)
            7'b0000011: begin
                bad = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
                dec.alu_source = 1'b1;
                dec.write_back_source = 2'd1;
                dec.reg_write = 1'b1;
                dec.mem_func3 = f3;
            end
            7'b0100011: begin
                bad = !(f3 inside {3'b000, 3'b001, 3'b010});
                dec.imm_source = 3'd1;
                dec.alu_source = 1'b1;
                dec.mem_write = 1'b1;
                dec.mem_func3 = f3;
            end
            7'b0010011: begin
                // No SUBI: only the shift-right slot uses instr[30].
                dec.alu_control = alu_of(f3, (f3 == 3'b101) && alt);
                dec.alu_source = 1'b1;
                dec.reg_write = 1'b1;
                if (STRICT_DECODE) begin
                    if (f3 == 3'b001) bad = (f7 != 7'b0000000);
                    if (f3 == 3'b101) bad = (f7 != 7'b0000000) && (f7 != 7'b0100000);
                end
            end
            7'b0110011: begin
                dec.alu_control = alu_of(f3, alt);
                dec.reg_write = 1'b1;
                if (STRICT_DECODE)
                    bad = !((f7 == 7'b0000000) ||
                            ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            7'b1100011: begin
                bad = (f3 == 3'b010) || (f3 == 3'b011);
                dec.imm_source = 3'd2;
                dec.branch = 1'b1;
                dec.branch_cond = f3;
                dec.alu_control = ALU_SUB;
            end
            7'b1101111: begin
                dec.imm_source = 3'd3;
                dec.write_back_source = 2'd2;
                dec.reg_write = 1'b1;
                dec.jump = 1'b1;
            end
            7'b1100111: begin
                bad = (f3 != 3'b000);
                dec.alu_source = 1'b1;
                dec.write_back_source = 2'd2;
                dec.reg_write = 1'b1;
                dec.jump = 1'b1;
                dec.jalr = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
                dec.imm_source = 3'd4;
                dec.write_back_source = 2'd3;
                dec.reg_write = 1'b1;
                dec.second_add_source = op[5];
            end
            7'b0001111: ;
            default: bad = 1'b1;
        endcase
        if (bad) begin
            dec = '0;
            dec.illegal = 1'b1;
        end
    end

    assign in_ready = !out_valid || out_ready || flush;
    assign load     = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_instr     <= '0;
            ctrl_q        <= '0;
            instr_count   <= '0;
            illegal_count <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (load) begin
                out_valid <= 1'b1;
                out_pc    <= in_pc;
                out_instr <= in_instr;
                ctrl_q    <= dec;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // Counters saturate so a long debug run never wraps to a misleading value.
            if (out_valid && out_ready && !flush) begin
                if (instr_count != '1) instr_count <= instr_count + 1'b1;
                if (ctrl_q.illegal && (illegal_count != '1)) illegal_count <= illegal_count + 1'b1;
            end
        end
    end

    assign alu_control       = ctrl_q.alu_control;
    assign imm_source        = ctrl_q.imm_source;
    assign alu_source        = ctrl_q.alu_source;
    assign write_back_source = ctrl_q.write_back_source;
    assign second_add_source = ctrl_q.second_add_source;
    assign reg_write         = ctrl_q.reg_write;
    assign mem_write         = ctrl_q.mem_write;
    assign mem_func3         = ctrl_q.mem_func3;
    assign branch            = ctrl_q.branch;
    assign branch_cond       = ctrl_q.branch_cond;
    assign jump              = ctrl_q.jump;
    assign jalr              = ctrl_q.jalr;
    assign illegal           = ctrl_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: strict default instance, a lenient-decode
// instance and a 2-bit-counter instance all share one stimulus stream.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    // strict, default parameters
    logic        in_ready, out_valid, alu_source, second_add_source, reg_write, mem_write;
    logic        branch, jump, jalr, illegal;
    logic [31:0] out_pc, out_instr;
    logic [3:0]  alu_control;
    logic [2:0]  imm_source, mem_func3, branch_cond;
    logic [1:0]  write_back_source;
    logic [15:0] instr_count, illegal_count;

    // lenient decode
    logic        l_in_ready, l_out_valid, l_alu_source, l_second_add_source, l_reg_write, l_mem_write;
    logic        l_branch, l_jump, l_jalr, l_illegal;
    logic [31:0] l_out_pc, l_out_instr;
    logic [3:0]  l_alu_control;
    logic [2:0]  l_imm_source, l_mem_func3, l_branch_cond;
    logic [1:0]  l_write_back_source;
    logic [15:0] l_instr_count, l_illegal_count;

    // 2-bit counters
    logic        c_in_ready, c_out_valid, c_alu_source, c_second_add_source, c_reg_write, c_mem_write;
    logic        c_branch, c_jump, c_jalr, c_illegal;
    logic [31:0] c_out_pc, c_out_instr;
    logic [3:0]  c_alu_control;
    logic [2:0]  c_imm_source, c_mem_func3, c_branch_cond;
    logic [1:0]  c_write_back_source;
    logic [1:0]  c_instr_count, c_illegal_count;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .alu_control(alu_control),
        .imm_source(imm_source), .alu_source(alu_source), .write_back_source(write_back_source),
        .second_add_source(second_add_source), .reg_write(reg_write), .mem_write(mem_write),
        .mem_func3(mem_func3), .branch(branch), .branch_cond(branch_cond), .jump(jump),
        .jalr(jalr), .illegal(illegal), .instr_count(instr_count), .illegal_count(illegal_count)
    );

    decode_stage #(.STRICT_DECODE(1'b0)) u_len (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(l_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(l_out_valid), .out_ready(out_ready),
        .out_pc(l_out_pc), .out_instr(l_out_instr), .alu_control(l_alu_control),
        .imm_source(l_imm_source), .alu_source(l_alu_source),
        .write_back_source(l_write_back_source), .second_add_source(l_second_add_source),
        .reg_write(l_reg_write), .mem_write(l_mem_write), .mem_func3(l_mem_func3),
        .branch(l_branch), .branch_cond(l_branch_cond), .jump(l_jump), .jalr(l_jalr),
        .illegal(l_illegal), .instr_count(l_instr_count), .illegal_count(l_illegal_count)
    );

    decode_stage #(.CNT_WIDTH(2)) u_cnt (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_pc(c_out_pc), .out_instr(c_out_instr), .alu_control(c_alu_control),
        .imm_source(c_imm_source), .alu_source(c_alu_source),
        .write_back_source(c_write_back_source), .second_add_source(c_second_add_source),
        .reg_write(c_reg_write), .mem_write(c_mem_write), .mem_func3(c_mem_func3),
        .branch(c_branch), .branch_cond(c_branch_cond), .jump(c_jump), .jalr(c_jalr),
        .illegal(c_illegal), .instr_count(c_instr_count), .illegal_count(c_illegal_count)
    );

    localparam logic [31:0] ADDI = 32'h0050_0093, SUB = 32'h4020_8033, SRL = 32'h0020_D0B3;
    localparam logic [31:0] BEQ = 32'h0020_8463, SLLI_BAD = 32'h0220_9093, JALR = 32'h0000_80E7;
    localparam logic [31:0] SW = 32'h0020_A223, LUI = 32'h1234_50B7, ECALL = 32'h0000_0073;
    localparam logic [31:0] BR_BAD = 32'h0020_A463, OP_BAD = 32'h4020_9033;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_alu_control", {28'd0, alu_control}, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_instr_count", {16'd0, instr_count}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;

        drive(ADDI, 32'h100);
        tick();
        chk("addi_valid", {31'd0, out_valid}, 32'd1);
        chk("addi_alu", {28'd0, alu_control}, 32'd0);
        chk("addi_alu_src", {31'd0, alu_source}, 32'd1);
        chk("addi_reg_write", {31'd0, reg_write}, 32'd1);
        chk("addi_pc", out_pc, 32'h100);
        chk("addi_cnt_before_xfer", {16'd0, instr_count}, 32'd0);

        drive(SUB, 32'h104);
        #1 chk("sub_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("sub_alu", {28'd0, alu_control}, 32'd1);
        chk("sub_pc", out_pc, 32'h104);
        chk("cnt_after_addi", {16'd0, instr_count}, 32'd1);
        chk("c_cnt_1", {30'd0, c_instr_count}, 32'd1);

        drive(SRL, 32'h108);
        #1 chk("srl_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("srl_alu", {28'd0, alu_control}, 32'd6);
        chk("cnt_2", {16'd0, instr_count}, 32'd2);
        chk("c_cnt_2", {30'd0, c_instr_count}, 32'd2);

        drive(BEQ, 32'h10C);
        tick();
        chk("beq_branch", {31'd0, branch}, 32'd1);
        chk("beq_cond", {29'd0, branch_cond}, 32'd0);
        chk("beq_alu", {28'd0, alu_control}, 32'd1);
        chk("beq_imm", {29'd0, imm_source}, 32'd2);

        out_ready = 1'b0;
        drive(SLLI_BAD, 32'h110);
        #1 chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("hold1_instr", out_instr, BEQ);
        chk("hold1_pc", out_pc, 32'h10C);
        chk("hold1_branch", {31'd0, branch}, 32'd1);
        chk("hold1_cnt", {16'd0, instr_count}, 32'd3);
        tick();
        chk("hold2_instr", out_instr, BEQ);
        chk("hold2_valid", {31'd0, out_valid}, 32'd1);
        chk("hold2_cnt", {16'd0, instr_count}, 32'd3);

        out_ready = 1'b1;
        #1 chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("slli_strict_illegal", {31'd0, illegal}, 32'd1);
        chk("slli_strict_reg_write", {31'd0, reg_write}, 32'd0);
        chk("slli_strict_alu", {28'd0, alu_control}, 32'd0);
        chk("slli_len_illegal", {31'd0, l_illegal}, 32'd0);
        chk("slli_len_alu", {28'd0, l_alu_control}, 32'd4);
        chk("slli_len_reg_write", {31'd0, l_reg_write}, 32'd1);

        in_valid = 1'b0;
        tick();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_ill_cnt", {16'd0, illegal_count}, 32'd1);
        chk("drain_cnt", {16'd0, instr_count}, 32'd5);
        chk("c_cnt_sat", {30'd0, c_instr_count}, 32'd3);
        chk("len_ill_cnt", {16'd0, l_illegal_count}, 32'd0);

        drive(ADDI, 32'h200);
        tick();
        chk("pre_flush_valid", {31'd0, out_valid}, 32'd1);
        flush = 1'b1;
        drive(JALR, 32'h204);
        #1 chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_cnt", {16'd0, instr_count}, 32'd5);
        chk("flush_ill_cnt", {16'd0, illegal_count}, 32'd1);

        flush = 1'b0;
        tick();
        chk("jalr_valid", {31'd0, out_valid}, 32'd1);
        chk("jalr_jump", {31'd0, jump}, 32'd1);
        chk("jalr_jalr", {31'd0, jalr}, 32'd1);
        chk("jalr_wb", {30'd0, write_back_source}, 32'd2);
        chk("jalr_alu_src", {31'd0, alu_source}, 32'd1);
        chk("jalr_pc", out_pc, 32'h204);

        drive(SW, 32'h208);
        tick();
        chk("sw_mem_write", {31'd0, mem_write}, 32'd1);
        chk("sw_reg_write", {31'd0, reg_write}, 32'd0);
        chk("sw_imm", {29'd0, imm_source}, 32'd1);
        chk("sw_f3", {29'd0, mem_func3}, 32'd2);
        chk("sw_cnt", {16'd0, instr_count}, 32'd6);

        drive(LUI, 32'h20C);
        tick();
        chk("lui_wb", {30'd0, write_back_source}, 32'd3);
        chk("lui_second_add", {31'd0, second_add_source}, 32'd1);
        chk("lui_imm", {29'd0, imm_source}, 32'd4);
        chk("lui_reg_write", {31'd0, reg_write}, 32'd1);

        drive(ECALL, 32'h210);
        tick();
        chk("ecall_illegal", {31'd0, illegal}, 32'd1);
        chk("ecall_reg_write", {31'd0, reg_write}, 32'd0);

        drive(BR_BAD, 32'h214);
        tick();
        chk("brbad_illegal", {31'd0, illegal}, 32'd1);
        chk("brbad_branch", {31'd0, branch}, 32'd0);
        chk("brbad_len_illegal", {31'd0, l_illegal}, 32'd1);

        drive(OP_BAD, 32'h218);
        tick();
        chk("opbad_strict_illegal", {31'd0, illegal}, 32'd1);
        chk("opbad_len_alu", {28'd0, l_alu_control}, 32'd4);
        chk("opbad_len_illegal", {31'd0, l_illegal}, 32'd0);

        in_valid = 1'b0;
        tick();
        chk("end_valid", {31'd0, out_valid}, 32'd0);
        chk("end_cnt", {16'd0, instr_count}, 32'd11);
        chk("end_ill_cnt", {16'd0, illegal_count}, 32'd4);
        chk("end_len_ill_cnt", {16'd0, l_illegal_count}, 32'd2);
        chk("end_c_cnt", {30'd0, c_instr_count}, 32'd3);

        drive(ADDI, 32'h300);
        out_ready = 1'b0;
        tick();
        chk("midhold_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_reg_write", {31'd0, reg_write}, 32'd0);
        chk("async_rst_alu_src", {31'd0, alu_source}, 32'd0);
        chk("async_rst_instr", out_instr, 32'd0);
        chk("async_rst_cnt", {16'd0, instr_count}, 32'd0);
        chk("async_rst_ill_cnt", {16'd0, illegal_count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
